// File: rtl/cpu_pkg.sv
// Shared decode constants, FSM state type, flag/compare bit positions and the
// branch-condition evaluator for multicycle_cpu and cpu_alu.
package cpu_pkg;

  localparam logic [1:0] GRP_ALU = 2'd0;
  localparam logic [1:0] GRP_LD  = 2'd1;
  localparam logic [1:0] GRP_STR = 2'd2;
  localparam logic [1:0] GRP_EXT = 2'd3;

  localparam logic [1:0] EXT_RES  = 2'd0;
  localparam logic [1:0] EXT_COMP = 2'd1;
  localparam logic [1:0] EXT_JUMP = 2'd2;
  localparam logic [1:0] EXT_NOP  = 2'd3;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_NOT = 4'd5;
  localparam logic [3:0] ALU_SHL = 4'd6;
  localparam logic [3:0] ALU_SHR = 4'd7;
  localparam logic [3:0] ALU_MOV = 4'd8;
  localparam logic [3:0] ALU_MUL = 4'd15;

  localparam logic [3:0] COND_ALWAYS = 4'd0;
  localparam logic [3:0] COND_EQ     = 4'd1;
  localparam logic [3:0] COND_NE     = 4'd2;
  localparam logic [3:0] COND_GT     = 4'd3;
  localparam logic [3:0] COND_LT     = 4'd4;
  localparam logic [3:0] COND_GE     = 4'd5;
  localparam logic [3:0] COND_LE     = 4'd6;
  localparam logic [3:0] COND_Z      = 4'd7;
  localparam logic [3:0] COND_NZ     = 4'd8;
  localparam logic [3:0] COND_C      = 4'd9;
  localparam logic [3:0] COND_NC     = 4'd10;
  localparam logic [3:0] COND_N      = 4'd11;
  localparam logic [3:0] COND_NN     = 4'd12;
  localparam logic [3:0] COND_V      = 4'd13;
  localparam logic [3:0] COND_NV     = 4'd14;
  localparam logic [3:0] COND_NEVER  = 4'd15;

  typedef enum logic [1:0] {FETCH = 2'd0, EXEC = 2'd1, MEM = 2'd2} cpuState_t;

  // flags = {V,C,N,Z}; compare latch = {GT,EQ,LT}
  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;
  localparam int CMP_LT = 0;
  localparam int CMP_EQ = 1;
  localparam int CMP_GT = 2;

  function automatic logic condHolds(input logic [3:0] cond, input logic [2:0] cmp,
                                     input logic [3:0] fl);
    logic hit;
    case (cond)
      COND_ALWAYS: hit = 1'b1;
      COND_EQ:     hit = cmp[CMP_EQ];
      COND_NE:     hit = ~cmp[CMP_EQ];
      COND_GT:     hit = cmp[CMP_GT];
      COND_LT:     hit = cmp[CMP_LT];
      COND_GE:     hit = cmp[CMP_GT] | cmp[CMP_EQ];
      COND_LE:     hit = cmp[CMP_LT] | cmp[CMP_EQ];
      COND_Z:      hit = fl[FLAG_Z];
      COND_NZ:     hit = ~fl[FLAG_Z];
      COND_C:      hit = fl[FLAG_C];
      COND_NC:     hit = ~fl[FLAG_C];
      COND_N:      hit = fl[FLAG_N];
      COND_NN:     hit = ~fl[FLAG_N];
      COND_V:      hit = fl[FLAG_V];
      COND_NV:     hit = ~fl[FLAG_V];
      default:     hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU with {V,C,N,Z} flag generation.
// Op 15 is an unsigned multiply when MULTICYCLE_CPU_MUL_EN is defined, else MOV x.
module cpu_alu import cpu_pkg::*; #(
  parameter int DATA_W = 16
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic [3:0]        flagsOut
);

  localparam int MSB = DATA_W - 1;

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;
  logic            c;
  logic            v;

`ifdef MULTICYCLE_CPU_MUL_EN
  logic [2*DATA_W-1:0] prod;
  assign prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
`endif

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    result = a;
    c      = 1'b0;
    v      = 1'b0;
    case (op)
      ALU_ADD: begin
        result = sum[MSB:0];
        c      = sum[DATA_W];
        v      = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      ALU_SUB: begin
        // carry here means no borrow, i.e. a >= b unsigned
        result = diff[MSB:0];
        c      = ~diff[DATA_W];
        v      = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_NOT: result = ~a;
      ALU_SHL: begin
        result = {a[MSB-1:0], 1'b0};
        c      = a[MSB];
      end
      ALU_SHR: begin
        result = {1'b0, a[MSB:1]};
        c      = a[0];
      end
`ifdef MULTICYCLE_CPU_MUL_EN
      ALU_MUL: begin
        result = prod[MSB:0];
        c      = |prod[2*DATA_W-1:DATA_W];
      end
`endif
      default: result = a;
    endcase
    flagsOut         = '0;
    flagsOut[FLAG_Z] = (result == '0);
    flagsOut[FLAG_N] = result[MSB];
    flagsOut[FLAG_C] = c;
    flagsOut[FLAG_V] = v;
  end

endmodule

// File: rtl/multicycle_cpu.sv
// Multicycle CPU: FETCH -> EXEC (-> MEM for loads/stores) with req/ack memory ports.
// Optional multiplier in the ALU is enabled by defining MULTICYCLE_CPU_MUL_EN.
module multicycle_cpu import cpu_pkg::*; #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 12,
  parameter int REG_COUNT = 16
) (
  input  logic              clk,
  input  logic              res,
  input  logic              enable,
  output logic [ADDR_W-1:0] instr_addr,
  output logic              instr_req,
  input  logic              instr_ack,
  input  logic [31:0]       instruction,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  input  logic [DATA_W-1:0] data_rdata,
  output logic              data_req,
  output logic              data_we,
  input  logic              data_ack,
  output logic [3:0]        flags,
  output cpuState_t         dbgState
);

  localparam int RW = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;

  // Handshake rule: a request, once raised, holds with stable address/data until
  // the cycle in which ack is sampled high; ack while the request is low is ignored.
  cpuState_t         state, nextState;
  logic [31:0]       ir;
  logic [ADDR_W-1:0] pc, pcNext;
  logic [DATA_W-1:0] regs [REG_COUNT];
  logic [3:0]        flagReg;
  logic [2:0]        cmpReg;
  logic              fetchHeld;

  logic [1:0]        grp, extOp;
  logic [3:0]        aluOp, cond;
  logic              isImm, regWr, isMemOp;
  logic [RW-1:0]     zIdx, xIdx, yIdx;
  logic [DATA_W-1:0] rx, ry, rz, immVal, aluRes, regWd;
  logic [ADDR_W-1:0] immAddr, memAddr;
  logic [3:0]        aluFlags;
  logic              fetchDone, memDone, regWe, softReset;

  assign grp     = ir[1:0];
  assign extOp   = ir[3:2];
  assign aluOp   = ir[5:2];
  assign zIdx    = ir[6 +: RW];
  assign xIdx    = ir[10 +: RW];
  assign yIdx    = ir[14 +: RW];
  assign cond    = ir[29:26];
  assign regWr   = ir[30];
  assign isImm   = ir[31];
  assign immAddr = ir[10 +: ADDR_W];
  assign immVal  = DATA_W'(ir[25:10]);
  assign rx      = regs[xIdx];
  assign ry      = regs[yIdx];
  assign rz      = regs[zIdx];
  assign memAddr = isImm ? immAddr : ry[ADDR_W-1:0];
  assign isMemOp = (grp == GRP_LD) || (grp == GRP_STR);

  assign fetchDone = instr_req && instr_ack;
  assign memDone   = data_req && data_ack;

  assign instr_addr = pc;
  assign data_addr  = memAddr;
  assign data_wdata = rz;
  assign flags      = flagReg;
  assign dbgState   = state;

  cpu_alu #(.DATA_W(DATA_W)) uAlu (
    .op       (aluOp),
    .a        (rx),
    .b        (ry),
    .result   (aluRes),
    .flagsOut (aluFlags)
  );

  always_ff @(posedge clk or posedge res) begin
    if (res) state <= FETCH;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      FETCH:   if (fetchDone) nextState = EXEC;
      EXEC:    nextState = isMemOp ? MEM : FETCH;
      MEM:     if (memDone) nextState = FETCH;
      default: nextState = FETCH;
    endcase
  end

  // Requests are gated by res so they drop in the same cycle reset asserts.
  always_comb begin
    instr_req = 1'b0;
    data_req  = 1'b0;
    data_we   = 1'b0;
    if (!res) begin
      case (state)
        FETCH: instr_req = enable | fetchHeld;
        MEM: begin
          data_req = 1'b1;
          data_we  = (grp == GRP_STR);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    regWe     = 1'b0;
    regWd     = aluRes;
    softReset = 1'b0;
    pcNext    = pc;
    if (state == EXEC) begin
      if (grp == GRP_ALU) begin
        regWe = regWr;
        regWd = isImm ? immVal : aluRes;
      end
      if (grp == GRP_EXT) softReset = (extOp == EXT_RES);
      if (!isMemOp) begin
        if (grp == GRP_EXT && extOp == EXT_JUMP && condHolds(cond, cmpReg, flagReg))
          pcNext = memAddr;
        else
          pcNext = pc + ADDR_W'(1);
      end
    end else if (state == MEM && memDone) begin
      regWe  = regWr && (grp == GRP_LD);
      regWd  = data_rdata;
      pcNext = pc + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      ir        <= '0;
      pc        <= '0;
      flagReg   <= '0;
      cmpReg    <= '0;
      fetchHeld <= 1'b0;
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else begin
      fetchHeld <= instr_req && !instr_ack;
      if (fetchDone) ir <= instruction;
      if (softReset) begin
        pc      <= '0;
        flagReg <= '0;
        cmpReg  <= '0;
        for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
      end else begin
        pc <= pcNext;
        if (regWe) regs[zIdx] <= regWd;
        if (state == EXEC && grp == GRP_ALU && !isImm) flagReg <= aluFlags;
        if (state == EXEC && grp == GRP_EXT && extOp == EXT_COMP)
          cmpReg <= {rx > ry, rx == ry, rx < ry};
      end
    end
  end

endmodule

// File: tb/tb_multicycle_cpu.sv
// Directed, table-driven bench for multicycle_cpu; expected values are hand-computed.
// Define MULTICYCLE_CPU_MUL_EN for both RTL and bench to check the multiply variant.
module tb_multicycle_cpu;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        res;
  logic        enable;
  logic [11:0] instr_addr;
  logic        instr_req;
  logic        instr_ack;
  logic [31:0] instruction;
  logic [11:0] data_addr;
  logic [15:0] data_wdata;
  logic [15:0] data_rdata;
  logic        data_req;
  logic        data_we;
  logic        data_ack;
  logic [3:0]  flags;
  cpuState_t   dbgState;

  multicycle_cpu #(.DATA_W(16), .ADDR_W(12), .REG_COUNT(16)) dut (
    .clk         (clk),
    .res         (res),
    .enable      (enable),
    .instr_addr  (instr_addr),
    .instr_req   (instr_req),
    .instr_ack   (instr_ack),
    .instruction (instruction),
    .data_addr   (data_addr),
    .data_wdata  (data_wdata),
    .data_rdata  (data_rdata),
    .data_req    (data_req),
    .data_we     (data_we),
    .data_ack    (data_ack),
    .flags       (flags),
    .dbgState    (dbgState)
  );

  always #5 clk = ~clk;

`ifdef MULTICYCLE_CPU_MUL_EN
  localparam logic [3:0]  MUL_FLAGS = 4'b0101;
  localparam logic [15:0] MUL_RES   = 16'h0000;
`else
  localparam logic [3:0]  MUL_FLAGS = 4'b0000;
  localparam logic [15:0] MUL_RES   = 16'h0100;
`endif

  typedef struct {
    string       name;
    logic [31:0] instr;
    int          waitCycles;
    logic [15:0] rdata;
    logic [11:0] expPc;
    logic [3:0]  expFlags;
    logic        isMem;
    logic        isStore;
    logic [11:0] expAddr;
    logic [15:0] expWdata;
  } vec_t;

  vec_t        vecs[$];
  logic [15:0] expQ[$];
  int          nCompared = 0;
  int          nMismatched = 0;

  logic [11:0] memAddrSeen;
  logic        memWeSeen;
  logic [15:0] memWdataSeen;
  int          reqCycles;
  logic        stable;

  // ---------------- instruction encoders ----------------
  function automatic logic [31:0] aluR(logic [3:0] op, logic [3:0] z, logic [3:0] x,
                                       logic [3:0] y, logic wr);
    return {1'b0, wr, 4'b0, 8'b0, y, x, z, op, 2'd0};
  endfunction
  function automatic logic [31:0] aluI(logic [3:0] z, logic [15:0] val);
    return {1'b1, 1'b1, 4'b0, val, z, 4'b0, 2'd0};
  endfunction
  function automatic logic [31:0] ldI(logic [3:0] z, logic [11:0] addr);
    return {1'b1, 1'b1, 4'b0, 4'b0, addr, z, 4'b0, 2'd1};
  endfunction
  function automatic logic [31:0] ldR(logic [3:0] z, logic [3:0] y);
    return {1'b0, 1'b1, 4'b0, 8'b0, y, 4'b0, z, 4'b0, 2'd1};
  endfunction
  function automatic logic [31:0] strI(logic [3:0] z, logic [11:0] addr);
    return {1'b1, 1'b0, 4'b0, 4'b0, addr, z, 4'b0, 2'd2};
  endfunction
  function automatic logic [31:0] comp(logic [3:0] x, logic [3:0] y);
    return {1'b0, 1'b0, 4'b0, 8'b0, y, x, 4'b0, 2'b00, 2'd1, 2'd3};
  endfunction
  function automatic logic [31:0] jumpI(logic [3:0] c, logic [11:0] addr);
    return {1'b1, 1'b0, c, 4'b0, addr, 4'b0, 2'b00, 2'd2, 2'd3};
  endfunction
  function automatic logic [31:0] nopI();
    return {28'b0, 2'd3, 2'd3};
  endfunction
  function automatic logic [31:0] resI();
    return {28'b0, 2'd0, 2'd3};
  endfunction

  // ---------------- driver / checker tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic addVec(input string name, input logic [31:0] instr, input int waitCycles,
                        input logic [15:0] rdata, input logic [11:0] expPc,
                        input logic [3:0] expFlags, input logic isMem, input logic isStore,
                        input logic [11:0] expAddr, input logic [15:0] expWdata);
    vec_t v;
    v.name = name; v.instr = instr; v.waitCycles = waitCycles; v.rdata = rdata;
    v.expPc = expPc; v.expFlags = expFlags; v.isMem = isMem; v.isStore = isStore;
    v.expAddr = expAddr; v.expWdata = expWdata;
    vecs.push_back(v);
  endtask

  // Call at a negedge with the CPU idle in FETCH; returns at the negedge where it is back in FETCH.
  task automatic execOne(input logic [31:0] iw, input int waitCycles, input logic [15:0] rdata,
                         output int cycles);
    int  waited;
    int  guard;
    logic done;
    cycles = 0; waited = 0; guard = 0; done = 1'b0;
    reqCycles = 0; stable = 1'b1;
    instruction = iw; enable = 1'b1; instr_ack = 1'b1;
    @(posedge clk); cycles++;
    #1 enable = 1'b0; instr_ack = 1'b0;
    while (!done && guard < 64) begin
      @(negedge clk);
      guard++;
      if (dbgState == FETCH) begin
        done = 1'b1;
      end else begin
        data_ack = 1'b0;
        if (data_req) begin
          if (reqCycles == 0) begin
            memAddrSeen = data_addr; memWeSeen = data_we; memWdataSeen = data_wdata;
          end else if (data_addr !== memAddrSeen || data_wdata !== memWdataSeen) begin
            stable = 1'b0;
          end
          reqCycles++;
          if (waited < waitCycles) waited++;
          else begin data_ack = 1'b1; data_rdata = rdata; end
        end
        @(posedge clk); cycles++;
        #1 data_ack = 1'b0;
      end
    end
    if (!done) cycles = -1;
  endtask

  // ---------------- test ----------------
  initial begin
    int cyc;
    int expCyc;
    res = 1'b1; enable = 1'b1; instr_ack = 1'b0; instruction = '0;
    data_rdata = '0; data_ack = 1'b0;

    // reset state while res is held, even with enable high
    #12;
    check("rst.instr_req", 32'(instr_req), 32'd0);
    check("rst.data_req", 32'(data_req), 32'd0);
    check("rst.data_we", 32'(data_we), 32'd0);
    check("rst.pc", 32'(instr_addr), 32'd0);
    check("rst.flags", 32'(flags), 32'd0);
    @(negedge clk);
    res = 1'b0; enable = 1'b0;
    @(negedge clk);
    check("idle.instr_req", 32'(instr_req), 32'd0);
    check("idle.state", 32'(dbgState), 32'(FETCH));

    addVec("imm_r1",  aluI(4'd1, 16'h7FFF),                 0, 16'h0, 12'h001, 4'b0000, 0, 0, 12'h0, 16'h0);
    addVec("imm_r2",  aluI(4'd2, 16'h0001),                 0, 16'h0, 12'h002, 4'b0000, 0, 0, 12'h0, 16'h0);
    addVec("add_ovf", aluR(ALU_ADD, 4'd3, 4'd1, 4'd2, 1'b1), 0, 16'h0, 12'h003, 4'b1010, 0, 0, 12'h0, 16'h0);
    addVec("st_r3",   strI(4'd3, 12'h010),                  0, 16'h0, 12'h004, 4'b1010, 1, 1, 12'h010, 16'h8000);
    addVec("sub",     aluR(ALU_SUB, 4'd4, 4'd1, 4'd2, 1'b1), 0, 16'h0, 12'h005, 4'b0100, 0, 0, 12'h0, 16'h0);
    addVec("sub_z",   aluR(ALU_SUB, 4'd5, 4'd2, 4'd2, 1'b1), 0, 16'h0, 12'h006, 4'b0101, 0, 0, 12'h0, 16'h0);
    addVec("and",     aluR(ALU_AND, 4'd6, 4'd1, 4'd4, 1'b1), 0, 16'h0, 12'h007, 4'b0000, 0, 0, 12'h0, 16'h0);
    addVec("not",     aluR(ALU_NOT, 4'd7, 4'd2, 4'd0, 1'b1), 0, 16'h0, 12'h008, 4'b0010, 0, 0, 12'h0, 16'h0);
    addVec("shl",     aluR(ALU_SHL, 4'd8, 4'd3, 4'd0, 1'b1), 0, 16'h0, 12'h009, 4'b0101, 0, 0, 12'h0, 16'h0);
    addVec("shr",     aluR(ALU_SHR, 4'd9, 4'd2, 4'd0, 1'b1), 0, 16'h0, 12'h00A, 4'b0101, 0, 0, 12'h0, 16'h0);
    addVec("or",      aluR(ALU_OR, 4'd10, 4'd1, 4'd3, 1'b1), 0, 16'h0, 12'h00B, 4'b0010, 0, 0, 12'h0, 16'h0);
    addVec("xor",     aluR(ALU_XOR, 4'd11, 4'd10, 4'd1, 1'b1), 0, 16'h0, 12'h00C, 4'b0010, 0, 0, 12'h0, 16'h0);
    addVec("st_r11",  strI(4'd11, 12'h011),                 0, 16'h0, 12'h00D, 4'b0010, 1, 1, 12'h011, 16'h8000);
    addVec("ld_wait", ldI(4'd12, 12'h020),                  3, 16'hBEEF, 12'h00E, 4'b0010, 1, 0, 12'h020, 16'h0);
    addVec("st_r12",  strI(4'd12, 12'h012),                 0, 16'h0, 12'h00F, 4'b0010, 1, 1, 12'h012, 16'hBEEF);
    addVec("imm_r13", aluI(4'd13, 16'h0005),                0, 16'h0, 12'h010, 4'b0010, 0, 0, 12'h0, 16'h0);
    addVec("imm_r14", aluI(4'd14, 16'h0009),                0, 16'h0, 12'h011, 4'b0010, 0, 0, 12'h0, 16'h0);
    addVec("comp",    comp(4'd13, 4'd14),                   0, 16'h0, 12'h012, 4'b0010, 0, 0, 12'h0, 16'h0);
    addVec("jmp_gt",  jumpI(COND_GT, 12'h0FF),              0, 16'h0, 12'h013, 4'b0010, 0, 0, 12'h0, 16'h0);
    addVec("jmp_lt",  jumpI(COND_LT, 12'h0FF),              0, 16'h0, 12'h0FF, 4'b0010, 0, 0, 12'h0, 16'h0);
    addVec("jmp_eq",  jumpI(COND_EQ, 12'h200),              0, 16'h0, 12'h100, 4'b0010, 0, 0, 12'h0, 16'h0);
    addVec("jmp_z",   jumpI(COND_Z, 12'h300),               0, 16'h0, 12'h101, 4'b0010, 0, 0, 12'h0, 16'h0);
    addVec("imm_r15", aluI(4'd15, 16'h0100),                0, 16'h0, 12'h102, 4'b0010, 0, 0, 12'h0, 16'h0);
    addVec("op15",    aluR(ALU_MUL, 4'd15, 4'd15, 4'd15, 1'b1), 0, 16'h0, 12'h103, MUL_FLAGS, 0, 0, 12'h0, 16'h0);
    addVec("st_r15",  strI(4'd15, 12'h013),                 0, 16'h0, 12'h104, MUL_FLAGS, 1, 1, 12'h013, MUL_RES);
    addVec("mov",     aluR(ALU_MOV, 4'd0, 4'd1, 4'd0, 1'b1), 0, 16'h0, 12'h105, 4'b0000, 0, 0, 12'h0, 16'h0);
    addVec("st_r0",   strI(4'd0, 12'h014),                  0, 16'h0, 12'h106, 4'b0000, 1, 1, 12'h014, 16'h7FFF);
    addVec("jmp_end", jumpI(COND_ALWAYS, 12'hFFF),          0, 16'h0, 12'hFFF, 4'b0000, 0, 0, 12'h0, 16'h0);
    addVec("nop_wrap", nopI(),                              0, 16'h0, 12'h000, 4'b0000, 0, 0, 12'h0, 16'h0);
    addVec("ld_reg",  ldR(4'd1, 4'd13),                     0, 16'h1234, 12'h001, 4'b0000, 1, 0, 12'h005, 16'h0);
    addVec("st_r1",   strI(4'd1, 12'h015),                  0, 16'h0, 12'h002, 4'b0000, 1, 1, 12'h015, 16'h1234);
    addVec("add_nowr", aluR(ALU_ADD, 4'd11, 4'd11, 4'd11, 1'b0), 0, 16'h0, 12'h003, 4'b1101, 0, 0, 12'h0, 16'h0);
    addVec("st_r11b", strI(4'd11, 12'h016),                 0, 16'h0, 12'h004, 4'b1101, 1, 1, 12'h016, 16'h8000);
    addVec("soft_res", resI(),                              0, 16'h0, 12'h000, 4'b0000, 0, 0, 12'h0, 16'h0);
    addVec("st_r3z",  strI(4'd3, 12'h017),                  0, 16'h0, 12'h001, 4'b0000, 1, 1, 12'h017, 16'h0000);
    addVec("st_r13z", strI(4'd13, 12'h018),                 0, 16'h0, 12'h002, 4'b0000, 1, 1, 12'h018, 16'h0000);

    foreach (vecs[i]) begin
      if (vecs[i].isStore) expQ.push_back(vecs[i].expWdata);
      expCyc = vecs[i].isMem ? 3 + vecs[i].waitCycles : 2;
      execOne(vecs[i].instr, vecs[i].waitCycles, vecs[i].rdata, cyc);
      check({vecs[i].name, ".pc"}, 32'(instr_addr), 32'(vecs[i].expPc));
      check({vecs[i].name, ".flags"}, 32'(flags), 32'(vecs[i].expFlags));
      check({vecs[i].name, ".cycles"}, 32'(cyc), 32'(expCyc));
      if (vecs[i].isMem) begin
        check({vecs[i].name, ".addr"}, 32'(memAddrSeen), 32'(vecs[i].expAddr));
        check({vecs[i].name, ".we"}, 32'(memWeSeen), 32'(vecs[i].isStore));
        check({vecs[i].name, ".req_cycles"}, 32'(reqCycles), 32'(vecs[i].waitCycles + 1));
        if (vecs[i].waitCycles > 0) check({vecs[i].name, ".stable"}, 32'(stable), 32'd1);
      end
      if (vecs[i].isStore) begin
        if (expQ.size() > 0) check({vecs[i].name, ".wdata"}, 32'(memWdataSeen), 32'(expQ.pop_front()));
      end
    end

    // acks while no request is pending must be ignored (pc is 0x002 here)
    instr_ack = 1'b1; data_ack = 1'b1; instruction = jumpI(COND_ALWAYS, 12'h7AA);
    repeat (3) @(negedge clk);
    check("stray_ack.state", 32'(dbgState), 32'(FETCH));
    check("stray_ack.pc", 32'(instr_addr), 32'h002);
    instr_ack = 1'b0; data_ack = 1'b0;

    // fetch request stays up after enable drops until it is acknowledged
    instruction = nopI(); enable = 1'b1;
    @(posedge clk); #1;
    check("hold.req_up", 32'(instr_req), 32'd1);
    @(negedge clk);
    enable = 1'b0; #1;
    check("hold.req_kept", 32'(instr_req), 32'd1);
    check("hold.pc_kept", 32'(instr_addr), 32'h002);
    instr_ack = 1'b1;
    @(posedge clk); #1 instr_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("hold.pc_next", 32'(instr_addr), 32'h003);
    check("hold.idle_req", 32'(instr_req), 32'd0);

    // reset in the middle of a store
    execOne(aluI(4'd2, 16'h0055), 0, 16'h0, cyc);
    check("pre_rst.pc", 32'(instr_addr), 32'h004);
    instruction = strI(4'd2, 12'h030); enable = 1'b1; instr_ack = 1'b1; data_ack = 1'b0;
    @(posedge clk); #1 enable = 1'b0; instr_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_mem.data_req", 32'(data_req), 32'd1);
    check("mid_mem.data_we", 32'(data_we), 32'd1);
    res = 1'b1; #1;
    check("mid_rst.data_req", 32'(data_req), 32'd0);
    check("mid_rst.data_we", 32'(data_we), 32'd0);
    check("mid_rst.pc", 32'(instr_addr), 32'h000);
    @(posedge clk);
    @(negedge clk);
    res = 1'b0;
    @(negedge clk);
    check("mid_rst.state", 32'(dbgState), 32'(FETCH));
    execOne(strI(4'd2, 12'h031), 0, 16'h0, cyc);
    check("mid_rst.r2", 32'(memWdataSeen), 32'h0000);
    check("mid_rst.pc_after", 32'(instr_addr), 32'h001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
